// File: rtl/core_wb_pkg.sv
// Shared encodings for the write-back stage: result-select ops, FSM states and
// the load alignment / classification helpers.
package core_wb_pkg;

   typedef enum logic [2:0] {
      SX_BP  = 3'd0,
      SX_UB  = 3'd1,
      SX_B   = 3'd2,
      SX_H   = 3'd3,
      SX_UH  = 3'd4,
      SX_IMM = 3'd5,
      SX_PC  = 3'd6
   } sx_op_t;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_ACK = 1'b1
   } wb_state_t;

   function automatic logic is_load_op(input logic [2:0] op);
      return (op == SX_BP) || (op == SX_UB) || (op == SX_B) ||
             (op == SX_H)  || (op == SX_UH);
   endfunction

   // BP is word-granular even on a 64-bit datapath, so only the low two offset bits matter.
   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
      return (((op == SX_H) || (op == SX_UH)) && lo[0]) ||
             ((op == SX_BP) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/core_wb_if.sv
// MEM-stage to write-back bundle; master is the MEM side, slave is the write-back unit.
interface core_wb_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   localparam int OFF_W = $clog2(XLEN / 8);

   logic              wb_valid_in;
   logic [XLEN-1:0]   wb_alu_result_in;
   logic [XLEN-1:0]   wb_mem_data_in;
   logic [XLEN-1:0]   wb_pc_4_in;
   logic [XLEN-1:0]   wb_sx_imm_in;
   logic [2:0]        wb_sx_op_in;
   logic              wb_mux_in;
   logic [OFF_W-1:0]  wb_addr_lo_in;
   logic [RA_W-1:0]   wb_rd_in;
   logic              wb_we_in;
   logic              wb_ack_from_l1d_in;
   logic              wb_we_reg_file_out;
   logic [RA_W-1:0]   wb_rd_out;
   logic [XLEN-1:0]   wb_data_out;
   logic              wb_stall_out;
   logic              wb_err_out;
   logic              wb_fwd_valid_out;
   logic [RA_W-1:0]   wb_fwd_rd_out;

   modport master (
      output wb_valid_in, wb_alu_result_in, wb_mem_data_in, wb_pc_4_in, wb_sx_imm_in,
             wb_sx_op_in, wb_mux_in, wb_addr_lo_in, wb_rd_in, wb_we_in, wb_ack_from_l1d_in,
      input  wb_we_reg_file_out, wb_rd_out, wb_data_out, wb_stall_out, wb_err_out,
             wb_fwd_valid_out, wb_fwd_rd_out
   );

   modport slave (
      input  wb_valid_in, wb_alu_result_in, wb_mem_data_in, wb_pc_4_in, wb_sx_imm_in,
             wb_sx_op_in, wb_mux_in, wb_addr_lo_in, wb_rd_in, wb_we_in, wb_ack_from_l1d_in,
      output wb_we_reg_file_out, wb_rd_out, wb_data_out, wb_stall_out, wb_err_out,
             wb_fwd_valid_out, wb_fwd_rd_out
   );
endinterface

// File: rtl/core_wb_extract.sv
// Load-lane extraction: picks the byte/half/word addressed by the offset and
// sign- or zero-extends it to XLEN.
module core_wb_extract
   import core_wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]             mem_data,
   input  logic [2:0]                  sx_op,
   input  logic [$clog2(XLEN/8)-1:0]   addr_lo,
   output logic [XLEN-1:0]             data
);
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int NB    = XLEN / 8;
   localparam int NH    = XLEN / 16;

   logic [7:0]      byte_lanes [NB];
   logic [15:0]     half_lanes [NH];
   logic [7:0]      sel_byte;
   logic [15:0]     sel_half;
   logic [XLEN-1:0] word_ext;

   for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      assign byte_lanes[gi] = mem_data[gi*8 +: 8];
   end
   for (genvar gi = 0; gi < NH; gi++) begin : g_half
      assign half_lanes[gi] = mem_data[gi*16 +: 16];
   end

   assign sel_byte = byte_lanes[addr_lo];
   assign sel_half = half_lanes[addr_lo[OFF_W-1:1]];

   // On a 64-bit datapath BP is a 32-bit word load, sign-extended like LW.
   if (XLEN == 64) begin : g_word64
      logic [31:0] word;
      assign word     = addr_lo[2] ? mem_data[63:32] : mem_data[31:0];
      assign word_ext = {{(XLEN-32){word[31]}}, word};
   end else begin : g_word32
      assign word_ext = mem_data;
   end

   always_comb begin
      data = word_ext;
      case (sx_op)
         SX_B:    data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
         SX_UB:   data = {{(XLEN-8){1'b0}}, sel_byte};
         SX_H:    data = {{(XLEN-16){sel_half[15]}}, sel_half};
         SX_UH:   data = {{(XLEN-16){1'b0}}, sel_half};
         default: data = word_ext;
      endcase
   end

endmodule

// File: rtl/core_wb_unit.sv
// Write-back stage: result select, registered regfile write, and a load-wait
// FSM that stalls upstream until the L1D ack arrives or times out.
module core_wb_unit
   import core_wb_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RA_W      = 5,
   parameter int TMO_W     = 8,
   parameter int BYPASS_EN = 1
) (
   input  logic     clk,
   input  logic     rst,
   core_wb_if.slave wb
);
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

   wb_state_t         state_reg;
   logic [TMO_W-1:0]  tmo_cnt_reg;
   logic [RA_W-1:0]   pend_rd_reg;
   logic [2:0]        pend_op_reg;
   logic [OFF_W-1:0]  pend_lo_reg;
   logic              pend_we_reg;
   logic              we_reg;
   logic [RA_W-1:0]   rd_reg;
   logic [XLEN-1:0]   data_reg;
   logic              err_reg;

   logic              ack;
   logic              load_now;
   logic              tmo_hit;
   logic [2:0]        ext_op;
   logic [OFF_W-1:0]  ext_lo;
   logic [XLEN-1:0]   ext_data;
   logic              misal;
   logic [XLEN-1:0]   nonload_data;

   assign ack      = wb.wb_ack_from_l1d_in;
   assign load_now = wb.wb_valid_in & ~wb.wb_mux_in & is_load_op(wb.wb_sx_op_in);
   assign tmo_hit  = (state_reg == ST_WAIT_ACK) & ~ack & (tmo_cnt_reg == TMO_LAST);

   // One extractor serves both the same-cycle-ack path and the pending load.
   assign ext_op = (state_reg == ST_WAIT_ACK) ? pend_op_reg : wb.wb_sx_op_in;
   assign ext_lo = (state_reg == ST_WAIT_ACK) ? pend_lo_reg : wb.wb_addr_lo_in;
   assign misal  = misaligned(ext_op, ext_lo[1:0]);

   core_wb_extract #(.XLEN(XLEN)) u_extract (
      .mem_data (wb.wb_mem_data_in),
      .sx_op    (ext_op),
      .addr_lo  (ext_lo),
      .data     (ext_data)
   );

   always_comb begin
      nonload_data = wb.wb_alu_result_in;
      case (wb.wb_sx_op_in)
         SX_IMM:  nonload_data = wb.wb_sx_imm_in;
         SX_PC:   nonload_data = wb.wb_pc_4_in;
         default: nonload_data = wb.wb_alu_result_in;
      endcase
   end

   // While waiting, upstream is holding the pending load itself; dropping the stall retires it.
   assign wb.wb_stall_out = ~rst & ((state_reg == ST_IDLE) ? (load_now & ~ack)
                                                           : (~ack & ~tmo_hit));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         tmo_cnt_reg <= '0;
         pend_rd_reg <= '0;
         pend_op_reg <= '0;
         pend_lo_reg <= '0;
         pend_we_reg <= 1'b0;
         we_reg      <= 1'b0;
         rd_reg      <= '0;
         data_reg    <= '0;
         err_reg     <= 1'b0;
      end else begin
         we_reg  <= 1'b0;
         err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (wb.wb_valid_in && !load_now) begin
                  we_reg   <= wb.wb_we_in & (|wb.wb_rd_in);
                  rd_reg   <= wb.wb_rd_in;
                  data_reg <= nonload_data;
               end else if (load_now && ack) begin
                  we_reg   <= wb.wb_we_in & (|wb.wb_rd_in) & ~misal;
                  err_reg  <= misal;
                  rd_reg   <= wb.wb_rd_in;
                  data_reg <= ext_data;
               end else if (load_now) begin
                  pend_rd_reg <= wb.wb_rd_in;
                  pend_op_reg <= wb.wb_sx_op_in;
                  pend_lo_reg <= wb.wb_addr_lo_in;
                  pend_we_reg <= wb.wb_we_in;
                  tmo_cnt_reg <= '0;
                  state_reg   <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (ack) begin
                  we_reg    <= pend_we_reg & (|pend_rd_reg) & ~misal;
                  err_reg   <= misal;
                  rd_reg    <= pend_rd_reg;
                  data_reg  <= ext_data;
                  state_reg <= ST_IDLE;
               end else if (tmo_hit) begin
                  err_reg     <= 1'b1;
                  tmo_cnt_reg <= '0;
                  state_reg   <= ST_IDLE;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign wb.wb_we_reg_file_out = we_reg;
   assign wb.wb_rd_out          = rd_reg;
   assign wb.wb_data_out        = data_reg;
   assign wb.wb_err_out         = err_reg;

   if (BYPASS_EN != 0) begin : g_fwd
      assign wb.wb_fwd_valid_out = we_reg;
      assign wb.wb_fwd_rd_out    = rd_reg;
   end else begin : g_no_fwd
      assign wb.wb_fwd_valid_out = 1'b0;
      assign wb.wb_fwd_rd_out    = '0;
   end

endmodule
